cache_victim_ctrl: RTL and testbench

Miss-side replacement controller for the 4-way set-associative cache.
- Holds one 3-bit tree-PLRU state per set.
- Applies hit updates from the lookup pipeline.
- On a miss, picks a victim way. It sequences a writeback first if the victim is dirty, then a refill, then marks the refilled way most-recently-used.
- Sits between the cache lookup stage and the AXI read/write buffer controllers.

---
 rtl/cache_victim_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cache_victim_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_ctrl.sv
// Tree-PLRU replacement controller: per-set 3-bit PLRU, hit updates, and a miss
// sequencer (select victim -> optional writeback -> refill -> MRU update).
module cache_victim_ctrl #(
   parameter  int SET_NUM = 256,
   localparam int IDX_W   = $clog2(SET_NUM)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hit_valid,
   input  logic [IDX_W-1:0] hit_index,
   input  logic [3:0]       hit_way,
   input  logic             miss_req,
   output logic             miss_ready,
   input  logic [IDX_W-1:0] miss_index,
   input  logic [3:0]       miss_valid_vec,
   input  logic [3:0]       miss_dirty_vec,
   output logic             wb_req,
   output logic [1:0]       wb_way,
   input  logic             wb_ack,
   output logic             refill_req,
   output logic [1:0]       refill_way,
   input  logic             refill_ack,
   output logic             done_valid,
   output logic [1:0]       done_way,
   output logic [IDX_W-1:0] done_index
);

   typedef enum logic [2:0] {S_IDLE, S_SEL, S_WB, S_REFILL, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       valid_q, valid_d;
   logic [3:0]       dirty_q, dirty_d;
   logic [1:0]       way_q, way_d;
   logic             miss_ready_q, miss_ready_d;
   logic             wb_req_q, wb_req_d;
   logic             refill_req_q, refill_req_d;
   logic             done_valid_q, done_valid_d;
   logic [2:0]       plru_q [SET_NUM];
   logic [2:0]       plru_d [SET_NUM];

   logic [1:0]       hit_enc;
   logic [1:0]       sel_victim;
   logic             done_upd;

   function automatic logic [2:0] plru_access(input logic [2:0] s, input logic [1:0] w);
      logic [2:0] n;
      n = s;
      case (w)
         2'd3: begin n[2] = 1'b0; n[0] = 1'b0; end
         2'd2: begin n[2] = 1'b0; n[0] = 1'b1; end
         2'd1: begin n[2] = 1'b1; n[1] = 1'b0; end
         default: begin n[2] = 1'b1; n[1] = 1'b1; end
      endcase
      return n;
   endfunction

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      way_d        = way_q;
      miss_ready_d = miss_ready_q;
      wb_req_d     = wb_req_q;
      refill_req_d = refill_req_q;
      done_valid_d = done_valid_q;
      plru_d       = plru_q;
      done_upd     = 1'b0;

      // Multi-hot hit vectors resolve to the highest way.
      if (hit_way[3])      hit_enc = 2'd3;
      else if (hit_way[2]) hit_enc = 2'd2;
      else if (hit_way[1]) hit_enc = 2'd1;
      else                 hit_enc = 2'd0;

      if (!valid_q[0])      sel_victim = 2'd0;
      else if (!valid_q[1]) sel_victim = 2'd1;
      else if (!valid_q[2]) sel_victim = 2'd2;
      else if (!valid_q[3]) sel_victim = 2'd3;
      else if (!plru_q[idx_q][2]) sel_victim = {1'b0, plru_q[idx_q][1]};
      else                        sel_victim = {1'b1, plru_q[idx_q][0]};

      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
               idx_d        = miss_index;
               valid_d      = miss_valid_vec;
               dirty_d      = miss_dirty_vec;
               miss_ready_d = 1'b0;
               state_d      = S_SEL;
            end
         end
         S_SEL: begin
            way_d = sel_victim;
            if (valid_q[sel_victim] && dirty_q[sel_victim]) begin
               wb_req_d = 1'b1;
               state_d  = S_WB;
            end else begin
               refill_req_d = 1'b1;
               state_d      = S_REFILL;
            end
         end
         S_WB: begin
            if (wb_ack) begin
               wb_req_d     = 1'b0;
               refill_req_d = 1'b1;
               state_d      = S_REFILL;
            end
         end
         S_REFILL: begin
            if (refill_ack) begin
               refill_req_d = 1'b0;
               done_valid_d = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            done_upd     = 1'b1;
            done_valid_d = 1'b0;
            miss_ready_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            wb_req_d     = 1'b0;
            refill_req_d = 1'b0;
            done_valid_d = 1'b0;
            miss_ready_d = 1'b1;
            state_d      = S_IDLE;
         end
      endcase

      // The refilled way's MRU update takes priority over a same-set hit.
      if (hit_valid && (hit_way != 4'b0000) && !(done_upd && (hit_index == idx_q)))
         plru_d[hit_index] = plru_access(plru_q[hit_index], hit_enc);
      if (done_upd)
         plru_d[idx_q] = plru_access(plru_q[idx_q], way_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         way_q        <= '0;
         miss_ready_q <= 1'b1;
         wb_req_q     <= 1'b0;
         refill_req_q <= 1'b0;
         done_valid_q <= 1'b0;
         for (int i = 0; i < SET_NUM; i++) plru_q[i] <= 3'b000;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         way_q        <= way_d;
         miss_ready_q <= miss_ready_d;
         wb_req_q     <= wb_req_d;
         refill_req_q <= refill_req_d;
         done_valid_q <= done_valid_d;
         plru_q       <= plru_d;
      end
   end

   assign miss_ready = miss_ready_q;
   assign wb_req     = wb_req_q;
   assign wb_way     = way_q;
   assign refill_req = refill_req_q;
   assign refill_way = way_q;
   assign done_valid = done_valid_q;
   assign done_way   = way_q;
   assign done_index = idx_q;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Bench for cache_victim_ctrl: directed scenarios plus randomized misses/hits
// checked against a per-set tree-PLRU reference model.
module tb_cache_victim_ctrl;
   localparam int SET_NUM = 256;
   localparam int IDX_W   = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             hit_valid = 1'b0;
   logic [IDX_W-1:0] hit_index = '0;
   logic [3:0]       hit_way = '0;
   logic             miss_req = 1'b0;
   logic             miss_ready;
   logic [IDX_W-1:0] miss_index = '0;
   logic [3:0]       miss_valid_vec = '0;
   logic [3:0]       miss_dirty_vec = '0;
   logic             wb_req;
   logic [1:0]       wb_way;
   logic             wb_ack = 1'b0;
   logic             refill_req;
   logic [1:0]       refill_way;
   logic             refill_ack = 1'b0;
   logic             done_valid;
   logic [1:0]       done_way;
   logic [IDX_W-1:0] done_index;

   cache_victim_ctrl #(.SET_NUM(SET_NUM)) dut (
      .clk(clk), .reset(reset),
      .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
      .miss_req(miss_req), .miss_ready(miss_ready), .miss_index(miss_index),
      .miss_valid_vec(miss_valid_vec), .miss_dirty_vec(miss_dirty_vec),
      .wb_req(wb_req), .wb_way(wb_way), .wb_ack(wb_ack),
      .refill_req(refill_req), .refill_way(refill_way), .refill_ack(refill_ack),
      .done_valid(done_valid), .done_way(done_way), .done_index(done_index)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: tree bits per set {root, left, right}.
   logic [2:0] model [SET_NUM];
   bit         done_pend = 0;
   int         done_idx  = 0;
   logic [1:0] done_w    = '0;
   bit         rand_hits = 0;

   function automatic logic [2:0] m_access(input logic [2:0] s, input int w);
      logic [2:0] n;
      n = s;
      if (w == 3)      begin n[2] = 0; n[0] = 0; end
      else if (w == 2) begin n[2] = 0; n[0] = 1; end
      else if (w == 1) begin n[2] = 1; n[1] = 0; end
      else             begin n[2] = 1; n[1] = 1; end
      return n;
   endfunction

   function automatic int m_top(input logic [3:0] v);
      int t;
      t = 0;
      for (int i = 0; i < 4; i++) if (v[i]) t = i;
      return t;
   endfunction

   function automatic logic [1:0] m_victim(input logic [2:0] s, input logic [3:0] vv);
      for (int i = 0; i < 4; i++) if (!vv[i]) return 2'(i);
      return s[2] ? {1'b1, s[0]} : {1'b0, s[1]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: the model absorbs what was driven during the finished cycle.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < SET_NUM; i++) model[i] = 3'b000;
      end else begin
         if (hit_valid && hit_way != 0 && !(done_pend && int'(hit_index) == done_idx))
            model[hit_index] = m_access(model[hit_index], m_top(hit_way));
         if (done_pend)
            model[done_idx] = m_access(model[done_idx], int'(done_w));
      end
      done_pend = 0;
      @(negedge clk);
      if (rand_hits) begin
         hit_valid = 1'($urandom_range(0, 1));
         hit_index = IDX_W'($urandom_range(0, 7));
         hit_way   = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic do_miss(input int idx, input logic [3:0] vv, input logic [3:0] dv,
                          input int wb_cyc, input int rf_cyc, input logic [3:0] conf_hit,
                          input bit hold, input int nidx, input logic [3:0] nvv);
      logic [1:0] exp_v;
      bit         dirty_exp;
      miss_req = 1; miss_index = IDX_W'(idx); miss_valid_vec = vv; miss_dirty_vec = dv;
      chk("ready_idle", miss_ready, 1);
      tick();
      if (hold) begin
         miss_index = IDX_W'(nidx); miss_valid_vec = nvv; miss_dirty_vec = 4'b0000;
      end else miss_req = 0;
      if (rand_hits) begin wb_ack = 1'($urandom); refill_ack = 1'($urandom); end
      chk("ready_sel", miss_ready, 0);
      chk("sel_no_req", {wb_req, refill_req}, 0);
      exp_v = m_victim(model[idx], vv);
      dirty_exp = vv[exp_v] && dv[exp_v];
      tick();
      wb_ack = 0; refill_ack = 0;
      if (dirty_exp) begin
         for (int c = 0; c < wb_cyc; c++) begin
            chk("wb_req", wb_req, 1);
            chk("wb_way", wb_way, exp_v);
            chk("wb_no_refill", refill_req, 0);
            wb_ack = (c == wb_cyc - 1);
            if (rand_hits) refill_ack = 1'($urandom);
            tick();
            wb_ack = 0; refill_ack = 0;
         end
      end
      for (int c = 0; c < rf_cyc; c++) begin
         chk("refill_req", refill_req, 1);
         chk("refill_way", refill_way, exp_v);
         chk("refill_no_wb", wb_req, 0);
         refill_ack = (c == rf_cyc - 1);
         if (rand_hits) wb_ack = 1'($urandom);
         tick();
         refill_ack = 0; wb_ack = 0;
      end
      chk("done_valid", done_valid, 1);
      chk("done_way", done_way, exp_v);
      chk("done_index", done_index, idx);
      chk("done_no_refill", refill_req, 0);
      done_pend = 1; done_idx = idx; done_w = exp_v;
      if (conf_hit != 0) begin
         hit_valid = 1; hit_index = IDX_W'(idx); hit_way = conf_hit;
      end
      tick();
      if (conf_hit != 0) hit_valid = 0;
      chk("done_pulse", done_valid, 0);
      chk("ready_back", miss_ready, 1);
   endtask

   initial begin
      for (int i = 0; i < SET_NUM; i++) model[i] = 3'b000;
      tick();
      tick();
      reset = 0;
      chk("rst_ready", miss_ready, 1);
      chk("rst_reqs", {wb_req, refill_req, done_valid}, 0);
      chk("rst_ways", {wb_way, refill_way, done_way}, 0);
      chk("rst_index", done_index, 0);

      // Clean misses on one set walk the PLRU order (way0, then way2).
      do_miss(5, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0);
      do_miss(5, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0);
      // Invalid way wins regardless of PLRU or its dirty bit.
      do_miss(9, 4'b1011, 4'b0100, 1, 1, 4'b0000, 0, 0, 4'b0);
      // Dirty victim: writeback held three cycles before refill.
      do_miss(3, 4'b1111, 4'b0001, 3, 2, 4'b0000, 0, 0, 4'b0);

      // Hits then a miss; same-set hit coincides with DONE and must lose.
      hit_valid = 1; hit_index = 7; hit_way = 4'b1000;
      tick();
      hit_way = 4'b0010;
      tick();
      hit_valid = 0;
      do_miss(7, 4'b1111, 4'b0000, 1, 1, 4'b0001, 0, 0, 4'b0);
      do_miss(7, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0);

      // Reset during writeback aborts the miss and clears PLRU state.
      miss_req = 1; miss_index = 5; miss_valid_vec = 4'b1111; miss_dirty_vec = 4'b1111;
      tick();
      miss_req = 0;
      tick();
      chk("abort_wb_req", wb_req, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("abort_wb_drop", wb_req, 0);
      chk("abort_ready", miss_ready, 1);
      chk("abort_no_done", {done_valid, refill_req}, 0);
      tick();
      chk("abort_idle_done", done_valid, 0);
      do_miss(5, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0);

      // miss_req held across a busy miss: only one further handshake.
      do_miss(10, 4'b1111, 4'b0000, 1, 2, 4'b0000, 1, 11, 4'b1110);
      do_miss(11, 4'b1110, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0);
      tick();
      chk("single_handshake", miss_ready, 1);

      // Randomized traffic on a few sets with concurrent hits and stray acks.
      rand_hits = 1;
      for (int n = 0; n < 60; n++) begin
         do_miss($urandom_range(0, 7), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(1, 3), $urandom_range(1, 3), 4'b0000, 0, 0, 4'b0);
         if ($urandom_range(0, 1) == 1) tick();
      end
      rand_hits = 0;
      hit_valid = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
